// File: rtl/dma_pkg.sv
// Shared types for the DMA request/acknowledge priority stage.
package dma_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] dma_ch_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_REQ,
    ACTIVE
  } dma_pri_state_t;

endpackage

// File: rtl/dma_priority_if.sv
// Bus-side handshake (DREQ/HRQ/HLDA/DACK) and grant hand-off to timing control.
interface dma_priority_if;
  import dma_pkg::*;

  logic [3:0] DREQ;
  logic       HLDA;
  logic       XFER_DONE;
  logic       HRQ;
  logic [3:0] DACK;
  dma_ch_t    ACT_CH;
  logic       ACT_VLD;

  // Priority stage side
  modport master (
    input  DREQ, HLDA, XFER_DONE,
    output HRQ, DACK, ACT_CH, ACT_VLD
  );

  // Peripherals / CPU / timing control side
  modport slave (
    output DREQ, HLDA, XFER_DONE,
    input  HRQ, DACK, ACT_CH, ACT_VLD
  );

endinterface

// File: rtl/dma_pri_arbiter.sv
// Combinational channel picker: fixed order, or rotating with the
// last-serviced channel (rot_ptr) as lowest priority.
module dma_pri_arbiter
  import dma_pkg::*;
(
  input  logic [3:0] pending,
  input  dma_ch_t    rot_ptr,
  input  logic       rot_en,
  output dma_ch_t    win_ch,
  output logic       win_vld
);

  dma_ch_t    start;
  dma_ch_t    idx;
  dma_ch_t    first;
  logic [3:0] rotated;
  logic       found;

  // Rotate so the highest-priority channel sits at bit 0, find-first, rotate back
  always_comb begin
    start   = rot_en ? dma_ch_t'(rot_ptr + 2'd1) : '0;
    rotated = '0;
    first   = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx        = dma_ch_t'(dma_ch_t'(i) + start);
      rotated[i] = pending[idx];
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (rotated[i] && !found) begin
        first = dma_ch_t'(i);
        found = 1'b1;
      end
    end
    win_ch  = dma_ch_t'(first + start);
    win_vld = found;
  end

endmodule

// File: rtl/dma_priority.sv
// Request/acknowledge priority stage: syncs DREQ, raises HRQ, grants one
// channel on HLDA and releases the bus when timing control is done.
module dma_priority
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CH = dma_pkg::NUM_CH,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  dma_priority_if.master    bus,
  input  logic              CMD_CTRL_DIS,
  input  logic              CMD_ROT_PRI,
  input  logic              CMD_DREQ_LOW,
  input  logic              CMD_DACK_HIGH,
  input  logic [NUM_CH-1:0] MASK,
  input  logic [NUM_CH-1:0] SW_REQ,
  output logic [NUM_CH-1:0] REQ_STATUS
);

  dma_pri_state_t    state_q, state_d;
  logic [NUM_CH-1:0] req_q, req_d;
  logic              hrq_q, hrq_d;
  logic              act_vld_q, act_vld_d;
  logic [CH_W-1:0]   act_ch_q, act_ch_d;
  dma_ch_t           rot_ptr_q, rot_ptr_d;

  logic [NUM_CH-1:0] pending;
  dma_ch_t           win_ch;
  logic              win_vld;

  dma_pri_arbiter u_arb (
    .pending (pending),
    .rot_ptr (rot_ptr_q),
    .rot_en  (CMD_ROT_PRI),
    .win_ch  (win_ch),
    .win_vld (win_vld)
  );

  // Request sync stage and pending-request merge
  always_comb begin
    req_d   = bus.DREQ ^ {NUM_CH{CMD_DREQ_LOW}};
    pending = (req_q & ~MASK) | SW_REQ;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    hrq_d     = hrq_q;
    act_vld_d = act_vld_q;
    act_ch_d  = act_ch_q;
    rot_ptr_d = rot_ptr_q;
    case (state_q)
      IDLE: begin
        if (!CMD_CTRL_DIS && (|pending)) begin
          state_d = HOLD_REQ;
          hrq_d   = 1'b1;
        end
      end
      HOLD_REQ: begin
        if (bus.HLDA && win_vld) begin
          state_d   = ACTIVE;
          act_ch_d  = win_ch;
          act_vld_d = 1'b1;
        end else if (!win_vld) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
        end
      end
      ACTIVE: begin
        // Done takes precedence over a simultaneous HLDA fall
        if (bus.XFER_DONE) begin
          state_d   = IDLE;
          hrq_d     = 1'b0;
          act_vld_d = 1'b0;
          if (CMD_ROT_PRI) rot_ptr_d = act_ch_q;
        end else if (!bus.HLDA) begin
          state_d   = IDLE;
          hrq_d     = 1'b0;
          act_vld_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        hrq_d     = 1'b0;
        act_vld_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      req_q     <= '0;
      hrq_q     <= 1'b0;
      act_vld_q <= 1'b0;
      act_ch_q  <= '0;
      rot_ptr_q <= '1;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      hrq_q     <= hrq_d;
      act_vld_q <= act_vld_d;
      act_ch_q  <= act_ch_d;
      rot_ptr_q <= rot_ptr_d;
    end
  end

  // DACK polarity follows the command register live, so the reset value tracks it too
  always_comb begin
    bus.HRQ     = hrq_q;
    bus.ACT_VLD = act_vld_q;
    bus.ACT_CH  = act_ch_q;
    bus.DACK    = (act_vld_q ? (4'b0001 << act_ch_q) : 4'b0000) ^ {4{~CMD_DACK_HIGH}};
    REQ_STATUS  = req_q | SW_REQ;
  end

endmodule
